decode_stage: RTL and testbench
===============================

# decode_stage

Registered decode and operand-fetch stage that sits directly upstream of the execute ALU. It accepts 32-bit RV32 instructions over a valid/ready handshake and decodes them to `ALU_func_t`. It reads a 32×32 register file, builds the immediate, and presents `r1`/`r2`/`imm`/`ALU_func` to the ALU one cycle after acceptance. It owns the register file write port (from writeback) and a per-register busy scoreboard that stalls issue on RAW/WAW hazards.

## Interface
Parameters:
- none (XLEN fixed at 32, 32 architectural registers)

Ports:
- `clk`  in  1  single clock, all state rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  instruction offered
- `in_ready`  out  1  stage can accept
- `in_instr`  in  32  instruction word
- `wb_en`  in  1  register file write strobe
- `wb_rd`  in  5  write register index
- `wb_data`  in  32  write data
- `out_valid`  out  1  decoded bundle valid
- `out_ready`  in  1  execute consumes bundle
- `r1`, `r2`  out  32  operands to ALU
- `imm`  out  32 signed  immediate
- `ALU_func`  out  `ALU_func_t`  ALU operation
- `rd`  out  5  destination index
- `rd_we`  out  1  result must be written back
- `illegal`  out  1  instruction not decodable

## Operation
- Handshake: accept when `in_valid && in_ready`.
- `in_ready = (!out_valid || out_ready) && !hazard`.
- Output register loads on accept.
- `out_valid` clears when `out_ready && !accept`.
- Decode is driven by opcode/funct3/funct7:
  - `0110011`: 000/0000000 ADD, 000/0100000 SUB, 001 SLL, 010 SLT, 100 XOR, 101/0000000 SRL, 101/0100000 SRA, 110 OR, 111 AND.
  - `0010011` funct3 000: ADDI.
  - `1100011` funct3 000: EQL (BEQ compare).
- Operands and immediate per instruction type:
  - R-type: `r1=RF[rs1]`, `r2=RF[rs2]`, `imm=0`, `rd_we=1`.
  - ADDI: `r1=RF[rs1]`, `r2=0`, `imm=sext(instr[31:20])`, `rd_we=1`.
  - EQL: `r1=RF[rs1]`, `r2=RF[rs2]`, `imm=sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})`, `rd=0`, `rd_we=0`.
- Any other encoding:
  - It is still accepted, with `illegal=1`, `ALU_func=ADD`, `r1=r2=imm=0`, `rd_we=0`.
  - It does not touch the scoreboard.
- Register file:
  - `x0` reads 0.
  - Writes to `x0` are ignored.
  - Write occurs on `clk` when `wb_en`.
- Scoreboard: `busy[31:1]`.
  - On accept with `rd_we && rd!=0`, set `busy[rd]`.
  - On `wb_en`, clear `busy[wb_rd]`.
  - Set wins over clear for the same index in the same cycle.
- `hazard = in_valid && (busy_eff[rs1] || busy_eff[rs2] || (rd_we_dec && busy_eff[rd]))`.
  - Only fields the decoded type actually uses count.
  - Index 0 never counts.

## Timing
- Reset (async assert, sync release):
  - `out_valid=0`, `r1=r2=imm=0`, `ALU_func=ADD`, `rd=0`, `rd_we=0`, `illegal=0`.
  - All `busy=0`, all RF entries 0.
  - `in_ready` follows its equation (1 after reset).
- Latency: accept in cycle N gives `out_valid=1` in N+1.
- Throughput: 1 instruction per cycle when no hazard and `out_ready=1`.
- Backpressure: while `out_valid && !out_ready`, all outputs hold stable.
- Reset mid-operation:
  - The in-flight bundle is dropped.
  - The scoreboard is cleared.
  - The writeback of a dropped instruction arriving later is allowed; clearing a bit that is already 0 is harmless.

## Configuration
- `DECODE_FORWARD_EN`, when defined:
  - Same-cycle writeback bypass: a read of `wb_rd` (≠0) while `wb_en` returns `wb_data`.
  - `busy_eff = busy & ~(wb_en ? onehot(wb_rd) : 0)`, so the stall drops in the writeback cycle.
- When undefined:
  - Reads return the pre-write RF value.
  - `busy_eff = busy`, so a dependent instruction issues the cycle after writeback.

## Structure
- Additions to `TypesPkg`:
  - opcode constants `OP_REG`, `OP_IMM`, `OP_BRANCH`;
  - `funct7` constants `F7_BASE`, `F7_ALT`;
  - a `decoded_t` struct (`ALU_func`, `rd`, `rd_we`, `imm`, `illegal`, `use_rs1`, `use_rs2`).
- `ALU_func_t` is reused unchanged.
- One sub-module: `regfile_2r1w`.
  - Two async read ports, one sync write port, asynchronous reset.
  - Forwarding mux lives inside it under the macro.
- Decode logic, scoreboard and output register live in `decode_stage`.

## Test plan
- Reset, then `add x3,x1,x2` (`0x002081B3`) with RF x1=5, x2=7:
  - next cycle `out_valid=1`, `ALU_func=ADD`, `r1=5`, `r2=7`, `rd=3`, `rd_we=1`.
- `addi x1,x0,-1` (`0xFFF00093`):
  - `ALU_func=ADDI`, `r1=0`, `imm=0xFFFFFFFF`, `r2=0`.
- RAW hazard: `addi x1,x0,4` then `add x2,x1,x1` held valid.
  - `in_ready=0` until writeback `wb_rd=1`, `wb_data=4`.
  - With the macro, the second instruction is accepted in the writeback cycle with `r1=r2=4`.
  - Without the macro, it is accepted the following cycle.
- Backpressure: `out_ready=0` for 3 cycles with `in_valid=1`.
  - Outputs stable, `in_ready=0`, no instruction lost or duplicated.
- Illegal `0x0000007F`:
  - `illegal=1`, `rd_we=0`, no busy bit set, next instruction not stalled.
- Assert `rst_n=0` while `busy[5]=1` and `out_valid=1`:
  - all outputs at reset values immediately;
  - after release, an instruction reading x5 issues without stall and reads 0.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared types for the decode stage: ALU ops, opcodes, decoded bundle
package TypesPkg;

    typedef enum logic [3:0] {
        ADD, SUB, SLL, SLT, XOR, SRL, SRA, OR, AND, ADDI, EQL
    } ALU_func_t;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        ALU_func_t   ALU_func;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] imm;
        logic        illegal;
        logic        use_rs1;
        logic        use_rs2;
    } decoded_t;

endpackage

// File: rtl/decode_stage_regfile_2r1w.sv
// rtl/decode_stage_regfile_2r1w.sv - 32x32 register file, two async reads, one sync write
// DECODE_FORWARD_EN: same-cycle writeback data is bypassed onto the read ports.
module regfile_2r1w (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [4:0]  ra1_i,
    output logic [31:0] rd1_o,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] mem_q [32];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            mem_q[wa_i] <= wd_i;
        end
    end

`ifdef DECODE_FORWARD_EN
    always_comb begin
        rd1_o = (ra1_i == 5'd0) ? 32'd0 : mem_q[ra1_i];
        rd2_o = (ra2_i == 5'd0) ? 32'd0 : mem_q[ra2_i];
        if (we_i && (wa_i != 5'd0) && (wa_i == ra1_i)) rd1_o = wd_i;
        if (we_i && (wa_i != 5'd0) && (wa_i == ra2_i)) rd2_o = wd_i;
    end
`else
    always_comb begin
        rd1_o = (ra1_i == 5'd0) ? 32'd0 : mem_q[ra1_i];
        rd2_o = (ra2_i == 5'd0) ? 32'd0 : mem_q[ra2_i];
    end
`endif

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32 decode/operand-fetch stage with busy scoreboard
// DECODE_FORWARD_EN: writeback bypass and same-cycle stall release.
module decode_stage
    import TypesPkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic               wb_en,
    input  logic [4:0]         wb_rd,
    input  logic [31:0]        wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        r1,
    output logic [31:0]        r2,
    output logic signed [31:0] imm,
    output ALU_func_t          ALU_func,
    output logic [4:0]         rd,
    output logic               rd_we,
    output logic               illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        legal;
    decoded_t    dec;
    logic [31:0] rf_r1;
    logic [31:0] rf_r2;
    logic [31:0] busy_q, busy_d, busy_eff;
    logic        hazard;
    logic        accept;

    logic        out_valid_q, out_valid_d;
    logic [31:0] r1_q, r1_d, r2_q, r2_d, imm_q, imm_d;
    ALU_func_t   func_q, func_d;
    logic [4:0]  rd_q, rd_d;
    logic        rd_we_q, rd_we_d;
    logic        illegal_q, illegal_d;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];

    always_comb begin
        dec          = '0;
        dec.ALU_func = ADD;
        legal        = 1'b0;
        case (opcode)
            OP_REG: begin
                legal       = 1'b1;
                dec.rd      = in_instr[11:7];
                dec.rd_we   = 1'b1;
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_BASE)     dec.ALU_func = ADD;
                        else if (funct7 == F7_ALT) dec.ALU_func = SUB;
                        else                       legal = 1'b0;
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE)     dec.ALU_func = SRL;
                        else if (funct7 == F7_ALT) dec.ALU_func = SRA;
                        else                       legal = 1'b0;
                    end
                    3'b001: begin dec.ALU_func = SLL; legal = (funct7 == F7_BASE); end
                    3'b010: begin dec.ALU_func = SLT; legal = (funct7 == F7_BASE); end
                    3'b100: begin dec.ALU_func = XOR; legal = (funct7 == F7_BASE); end
                    3'b110: begin dec.ALU_func = OR;  legal = (funct7 == F7_BASE); end
                    3'b111: begin dec.ALU_func = AND; legal = (funct7 == F7_BASE); end
                    default: legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                legal        = (funct3 == 3'b000);
                dec.ALU_func = ADDI;
                dec.rd       = in_instr[11:7];
                dec.rd_we    = 1'b1;
                dec.use_rs1  = 1'b1;
                dec.imm      = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_BRANCH: begin
                legal        = (funct3 == 3'b000);
                dec.ALU_func = EQL;
                dec.use_rs1  = 1'b1;
                dec.use_rs2  = 1'b1;
                dec.imm      = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
            end
            default: legal = 1'b0;
        endcase
        // Undecodable words still flow downstream as an inert ADD of zeros.
        if (!legal) begin
            dec          = '0;
            dec.ALU_func = ADD;
            dec.illegal  = 1'b1;
        end
    end

    regfile_2r1w u_rf (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .ra1_i   (rs1),
        .rd1_o   (rf_r1),
        .ra2_i   (rs2),
        .rd2_o   (rf_r2),
        .we_i    (wb_en),
        .wa_i    (wb_rd),
        .wd_i    (wb_data)
    );

`ifdef DECODE_FORWARD_EN
    logic [31:0] wb_mask;
    assign wb_mask  = wb_en ? (32'd1 << wb_rd) : 32'd0;
    assign busy_eff = busy_q & ~wb_mask;
`else
    assign busy_eff = busy_q;
`endif

    assign hazard = in_valid &&
                    ((dec.use_rs1 && (rs1 != 5'd0) && busy_eff[rs1]) ||
                     (dec.use_rs2 && (rs2 != 5'd0) && busy_eff[rs2]) ||
                     (dec.rd_we && (dec.rd != 5'd0) && busy_eff[dec.rd]));

    assign in_ready = (!out_valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    // Clear first so a set for the same index in the same cycle wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_en) busy_d[wb_rd] = 1'b0;
        if (accept && dec.rd_we && (dec.rd != 5'd0)) busy_d[dec.rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        imm_d       = imm_q;
        func_d      = func_q;
        rd_d        = rd_q;
        rd_we_d     = rd_we_q;
        illegal_d   = illegal_q;
        if (accept) begin
            out_valid_d = 1'b1;
            r1_d        = dec.use_rs1 ? rf_r1 : 32'd0;
            r2_d        = dec.use_rs2 ? rf_r2 : 32'd0;
            imm_d       = dec.imm;
            func_d      = dec.ALU_func;
            rd_d        = dec.rd;
            rd_we_d     = dec.rd_we;
            illegal_d   = dec.illegal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            r1_q        <= '0;
            r2_q        <= '0;
            imm_q       <= '0;
            func_q      <= ADD;
            rd_q        <= '0;
            rd_we_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            imm_q       <= imm_d;
            func_q      <= func_d;
            rd_q        <= rd_d;
            rd_we_q     <= rd_we_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign r1        = r1_q;
    assign r2        = r2_q;
    assign imm       = $signed(imm_q);
    assign ALU_func  = func_q;
    assign rd        = rd_q;
    assign rd_we     = rd_we_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - table-driven bench for decode_stage plus hazard/backpressure/reset sequences
module tb_decode_stage;
    import TypesPkg::*;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic              wb_en;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       r1;
    logic [31:0]       r2;
    logic signed [31:0] imm;
    ALU_func_t         alu_func;
    logic [4:0]        rd;
    logic              rd_we;
    logic              illegal;

    int n_vec = 0;
    int n_err = 0;

    decode_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r1        (r1),
        .r2        (r2),
        .imm       (imm),
        .ALU_func  (alu_func),
        .rd        (rd),
        .rd_we     (rd_we),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        ALU_func_t   func;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mkvec(input string name, input logic [31:0] instr, input ALU_func_t func,
                                   input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                                   input logic [4:0] d, input logic we, input logic ill);
        vec_t v;
        v.name = name; v.instr = instr; v.func = func; v.r1 = a; v.r2 = b;
        v.imm = im; v.rd = d; v.rd_we = we; v.illegal = ill;
        return v;
    endfunction

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                          input logic [2:0] f3, input logic [4:0] d);
        return {f7, s2, s1, f3, d, 7'b0110011};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        wb_en = 1'b1; wb_rd = r; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " r1"}, r1, 32'd0);
        chk({tag, " r2"}, r2, 32'd0);
        chk({tag, " imm"}, imm, 32'd0);
        chk({tag, " func"}, 32'(alu_func), 32'(ADD));
        chk({tag, " rd"}, 32'(rd), 32'd0);
        chk({tag, " rd_we"}, 32'(rd_we), 32'd0);
        chk({tag, " illegal"}, 32'(illegal), 32'd0);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;

        // x1=5, x2=7, x6=3 preloaded through the writeback port.
        vt.push_back(mkvec("add",    32'h002081B3,                 ADD,  5, 7, 0, 3,  1, 0));
        vt.push_back(mkvec("sub",    rtype(F7_ALT, 2, 1, 3'd0, 10),  SUB,  5, 7, 0, 10, 1, 0));
        vt.push_back(mkvec("sll",    rtype(F7_BASE, 6, 1, 3'd1, 11), SLL,  5, 3, 0, 11, 1, 0));
        vt.push_back(mkvec("slt",    rtype(F7_BASE, 2, 1, 3'd2, 12), SLT,  5, 7, 0, 12, 1, 0));
        vt.push_back(mkvec("xor",    rtype(F7_BASE, 2, 1, 3'd4, 13), XOR,  5, 7, 0, 13, 1, 0));
        vt.push_back(mkvec("srl",    rtype(F7_BASE, 2, 1, 3'd5, 14), SRL,  5, 7, 0, 14, 1, 0));
        vt.push_back(mkvec("sra",    rtype(F7_ALT, 6, 2, 3'd5, 15),  SRA,  7, 3, 0, 15, 1, 0));
        vt.push_back(mkvec("or",     rtype(F7_BASE, 2, 1, 3'd6, 16), OR,   5, 7, 0, 16, 1, 0));
        vt.push_back(mkvec("and",    rtype(F7_BASE, 2, 1, 3'd7, 17), AND,  5, 7, 0, 17, 1, 0));
        vt.push_back(mkvec("addi+",  32'h12310993, ADDI, 7, 0, 32'h00000123, 19, 1, 0));
        vt.push_back(mkvec("beq16",  32'h00208863, EQL,  5, 7, 32'h00000010, 0, 0, 0));
        vt.push_back(mkvec("beqneg", 32'h80208063, EQL,  5, 7, 32'hFFFFF000, 0, 0, 0));
        vt.push_back(mkvec("beqb11", 32'h002080E3, EQL,  5, 7, 32'h00000800, 0, 0, 0));
        vt.push_back(mkvec("ill7f",  32'h0000007F, ADD,  0, 0, 0, 0, 0, 1));
        vt.push_back(mkvec("illmul", rtype(7'b0000001, 2, 1, 3'd0, 22), ADD, 0, 0, 0, 0, 0, 1));
        vt.push_back(mkvec("illsli", 32'h00109193, ADD,  0, 0, 0, 0, 0, 1));
        vt.push_back(mkvec("addi-1", 32'hFFF00093, ADDI, 0, 0, 32'hFFFFFFFF, 1, 1, 0));

        tick(); tick();
        chk_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;
        tick();

        wb_write(5'd1, 32'd5);
        wb_write(5'd2, 32'd7);
        wb_write(5'd6, 32'd3);

        foreach (vt[i]) begin
            in_instr = vt[i].instr; in_valid = 1'b1;
            #1;
            chk({vt[i].name, " in_ready"}, 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            chk({vt[i].name, " out_valid"}, 32'(out_valid), 32'd1);
            chk({vt[i].name, " func"}, 32'(alu_func), 32'(vt[i].func));
            chk({vt[i].name, " r1"}, r1, vt[i].r1);
            chk({vt[i].name, " r2"}, r2, vt[i].r2);
            chk({vt[i].name, " imm"}, imm, vt[i].imm);
            chk({vt[i].name, " rd"}, 32'(rd), 32'(vt[i].rd));
            chk({vt[i].name, " rd_we"}, 32'(rd_we), 32'(vt[i].rd_we));
            chk({vt[i].name, " illegal"}, 32'(illegal), 32'(vt[i].illegal));
        end
        tick();
        chk("drain out_valid", 32'(out_valid), 32'd0);

        // Release every destination the table marked busy.
        wb_write(5'd3, 0);
        for (int r = 10; r <= 17; r++) wb_write(5'(r), 0);
        wb_write(5'd19, 0);
        wb_write(5'd1, 32'd5);

        // RAW: addi x1,x0,4 then add x2,x1,x1 held valid.
        in_instr = 32'h00400093; in_valid = 1'b1;
        #1;
        chk("raw addi in_ready", 32'(in_ready), 32'd1);
        tick();
        in_instr = 32'h00108133;
        #1;
        chk("raw stall0 in_ready", 32'(in_ready), 32'd0);
        chk("raw addi imm", imm, 32'd4);
        tick();
        chk("raw stall1 in_ready", 32'(in_ready), 32'd0);
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd4;
        #1;
`ifdef DECODE_FORWARD_EN
        chk("raw wb-cycle in_ready", 32'(in_ready), 32'd1);
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
`else
        chk("raw wb-cycle in_ready", 32'(in_ready), 32'd0);
        tick();
        wb_en = 1'b0;
        #1;
        chk("raw post-wb in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
`endif
        chk("raw add out_valid", 32'(out_valid), 32'd1);
        chk("raw add r1", r1, 32'd4);
        chk("raw add r2", r2, 32'd4);
        chk("raw add rd", 32'(rd), 32'd2);
        tick();
        chk("raw drain out_valid", 32'(out_valid), 32'd0);
        wb_write(5'd2, 32'd7);

        // Backpressure: sub x20 accepted, xor x21 waits three cycles.
        out_ready = 1'b0;
        in_instr = rtype(F7_ALT, 2, 1, 3'd0, 20); in_valid = 1'b1;
        #1;
        chk("bp sub in_ready", 32'(in_ready), 32'd1);
        tick();
        in_instr = rtype(F7_BASE, 2, 1, 3'd4, 21);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp hold out_valid", 32'(out_valid), 32'd1);
            chk("bp hold in_ready", 32'(in_ready), 32'd0);
            chk("bp hold rd", 32'(rd), 32'd20);
            chk("bp hold func", 32'(alu_func), 32'(SUB));
            chk("bp hold r1", r1, 32'd4);
            chk("bp hold r2", r2, 32'd7);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp xor out_valid", 32'(out_valid), 32'd1);
        chk("bp xor rd", 32'(rd), 32'd21);
        chk("bp xor func", 32'(alu_func), 32'(XOR));
        tick();
        chk("bp drain out_valid", 32'(out_valid), 32'd0);
        wb_write(5'd20, 0);
        wb_write(5'd21, 0);

        // Illegal word with rd field x31 must not mark x31 busy.
        in_instr = 32'h00000FFF; in_valid = 1'b1;
        #1;
        chk("ill in_ready", 32'(in_ready), 32'd1);
        tick();
        in_instr = 32'h00108FB3;
        #1;
        chk("ill illegal", 32'(illegal), 32'd1);
        chk("ill rd_we", 32'(rd_we), 32'd0);
        chk("ill next in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("ill next rd", 32'(rd), 32'd31);
        chk("ill next rd_we", 32'(rd_we), 32'd1);
        chk("ill next illegal", 32'(illegal), 32'd0);
        tick();
        wb_write(5'd31, 0);

        // Reset while addi x5,x0,9 is held at the output and x5 is busy.
        out_ready = 1'b0;
        in_instr = 32'h00900293; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rst pre out_valid", 32'(out_valid), 32'd1);
        chk("rst pre rd", 32'(rd), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk); rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        in_instr = 32'h00528333; in_valid = 1'b1;
        #1;
        chk("postrst in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("postrst out_valid", 32'(out_valid), 32'd1);
        chk("postrst r1", r1, 32'd0);
        chk("postrst r2", r2, 32'd0);
        chk("postrst rd", 32'(rd), 32'd6);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
